// File: rtl/serial_debug_pkg.sv
// Shared framing constants and helpers for the serial debug ring.
package serial_debug_pkg;

  localparam int SF_BITS     = 144;
  localparam int SF_BYTES    = 18;
  localparam int SF_HDR_BITS = 16;
  localparam int SF_IDX_W    = 5;

  localparam logic [14:0] SF_BROADCAST_ADDR = 15'h7FFF;
  localparam logic [7:0]  READ_CMD_IDENT    = 8'h00;
  localparam logic [7:0]  READ_CMD_NODE     = 8'hFF;

  // Emitter states: waiting for a held frame, or streaming its bytes out.
  typedef enum logic {
    ST_IDLE,
    ST_EMIT
  } emit_state_t;

  // Byte idx of a superframe, MSB first (idx 0 is the top header byte).
  function automatic logic [7:0] sf_byte(input logic [SF_BITS-1:0] frame,
                                         input logic [SF_IDX_W-1:0] idx);
    return frame[SF_BITS-1-8*int'(idx) -: 8];
  endfunction

endpackage

// File: rtl/serial_debug_sync2.sv
// Two-flop synchronizer for one asynchronous chain signal.
module serial_debug_sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  // Two back-to-back flops; the first may go metastable, the second settles it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      // NOTE: non-blocking so both stages sample old values and form a true
      // two-stage pipeline; blocking here would collapse it into one flop.
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/serial_debug_frame_rx.sv
// Chain-return deserializer: reassembles 144-bit superframes from the debug
// ring and emits them as 18 MSB-first bytes over a valid/ready stream.
// Optional: define SERIAL_DEBUG_FRAME_RX_STATS_EN to add wrapping 16-bit
// frame / overrun / timeout counters.
module serial_debug_frame_rx
  import serial_debug_pkg::*;
#(
  parameter int IDLE_TICKS = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] prescaler,
  input  logic       debug_rx_data,
  input  logic       debug_rx_clk,
  output logic [7:0] byte_out,
  output logic       byte_valid,
  input  logic       byte_ready,
  output logic       frame_overrun,
  output logic       frame_timeout
`ifdef SERIAL_DEBUG_FRAME_RX_STATS_EN
  ,
  output logic [15:0] stat_frames,
  output logic [15:0] stat_overruns,
  output logic [15:0] stat_timeouts
`endif
);

  localparam logic [15:0]         IDLE_MAX  = 16'(IDLE_TICKS);
  localparam logic [7:0]          LAST_BIT  = 8'(SF_BITS - 1);
  localparam logic [SF_IDX_W-1:0] LAST_BYTE = SF_IDX_W'(SF_BYTES - 1);

  logic               data_sync, clk_sync, clk_prev, chain_edge;
  logic [SF_BITS-1:0] shift, hold;
  logic [7:0]         bit_cnt, tick_cnt;
  logic [15:0]        idle_cnt;
  logic               tick, frame_done, full;
  logic [SF_IDX_W-1:0] byte_idx;
  emit_state_t        state;
  logic               accept, last_accept, full_eff, capture, overrun_now;

  serial_debug_sync2 u_sync_data (.clk(clk), .rst(rst), .d(debug_rx_data), .q(data_sync));
  serial_debug_sync2 u_sync_clk  (.clk(clk), .rst(rst), .d(debug_rx_clk),  .q(clk_sync));

  assign chain_edge = clk_sync & ~clk_prev;
  assign tick       = (tick_cnt == prescaler);

  // Front end: edge detect, bit shifter, prescaler and idle timeout.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_prev      <= 1'b0;
      shift         <= '0;
      bit_cnt       <= '0;
      frame_done    <= 1'b0;
      tick_cnt      <= '0;
      idle_cnt      <= '0;
      frame_timeout <= 1'b0;
    end else begin
      clk_prev      <= clk_sync;
      frame_done    <= 1'b0;
      frame_timeout <= 1'b0;
      tick_cnt      <= tick ? 8'd0 : tick_cnt + 8'd1;
      if (chain_edge) begin
        shift    <= {shift[SF_BITS-2:0], data_sync};
        idle_cnt <= '0;
        if (bit_cnt == LAST_BIT) begin
          bit_cnt    <= '0;
          frame_done <= 1'b1;
        end else begin
          bit_cnt <= bit_cnt + 8'd1;
        end
      end else if (tick && idle_cnt != IDLE_MAX) begin
        idle_cnt <= idle_cnt + 16'd1;
        // Reaching the limit drops a partial frame; an empty shifter just waits.
        if (idle_cnt == IDLE_MAX - 16'd1 && bit_cnt != 8'd0) begin
          bit_cnt       <= '0;
          frame_timeout <= 1'b1;
        end
      end
    end
  end

  // The last byte leaving frees the holding register for a frame completing
  // in that same cycle, so that frame is captured rather than overrun.
  assign accept      = byte_valid & byte_ready;
  assign last_accept = (state == ST_EMIT) && accept && (byte_idx == LAST_BYTE);
  assign full_eff    = full & ~last_accept;
  assign capture     = frame_done & ~full_eff;
  assign overrun_now = frame_done & full_eff;

  // Holding register and byte emitter FSM with registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the wide holding register is reset too so a reset mid-emit can
      // never leak stale frame contents onto byte_out afterwards.
      hold          <= '0;
      full          <= 1'b0;
      state         <= ST_IDLE;
      byte_idx      <= '0;
      byte_out      <= '0;
      byte_valid    <= 1'b0;
      frame_overrun <= 1'b0;
    end else begin
      frame_overrun <= overrun_now;
      full          <= capture ? 1'b1 : full_eff;
      if (capture) hold <= shift;
      case (state)
        ST_IDLE: begin
          if (full) begin
            byte_idx   <= '0;
            byte_out   <= sf_byte(hold, '0);
            byte_valid <= 1'b1;
            state      <= ST_EMIT;
          end
        end
        ST_EMIT: begin
          if (accept) begin
            if (byte_idx == LAST_BYTE) begin
              byte_valid <= 1'b0;
              state      <= ST_IDLE;
            end else begin
              byte_idx <= byte_idx + 1'b1;
              byte_out <= sf_byte(hold, byte_idx + 1'b1);
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef SERIAL_DEBUG_FRAME_RX_STATS_EN
  // Event counters; they wrap naturally at 0xFFFF.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_frames   <= '0;
      stat_overruns <= '0;
      stat_timeouts <= '0;
    end else begin
      if (capture)       stat_frames   <= stat_frames + 16'd1;
      if (overrun_now)   stat_overruns <= stat_overruns + 16'd1;
      if (frame_timeout) stat_timeouts <= stat_timeouts + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_serial_debug_frame_rx.sv
// Self-checking bench for serial_debug_frame_rx: expected bytes are queued as
// frames are sent and a monitor compares every valid cycle against the head.
module tb_serial_debug_frame_rx;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] prescaler;
  logic       debug_rx_data, debug_rx_clk;
  logic [7:0] byte_out;
  logic       byte_valid, byte_ready;
  logic       frame_overrun, frame_timeout;
`ifdef SERIAL_DEBUG_FRAME_RX_STATS_EN
  logic [15:0] stat_frames, stat_overruns, stat_timeouts;
`endif

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];
  int ovr_seen = 0, to_seen = 0, exp_ovr = 0, exp_to = 0, exp_frames = 0;
  int ready_mode = 0;
  int phase_cnt  = 0;

  always #5 clk = ~clk;

  serial_debug_frame_rx #(.IDLE_TICKS(16)) dut (
    .clk(clk), .rst(rst), .prescaler(prescaler),
    .debug_rx_data(debug_rx_data), .debug_rx_clk(debug_rx_clk),
    .byte_out(byte_out), .byte_valid(byte_valid), .byte_ready(byte_ready),
    .frame_overrun(frame_overrun), .frame_timeout(frame_timeout)
`ifdef SERIAL_DEBUG_FRAME_RX_STATS_EN
    , .stat_frames(stat_frames), .stat_overruns(stat_overruns),
    .stat_timeouts(stat_timeouts)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: a frame is 18 bytes, most significant first.
  task automatic push_frame(input logic [143:0] f);
    for (int i = 0; i < 18; i++) exp_q.push_back(8'(f >> (8 * (17 - i))));
    exp_frames++;
  endtask

  // Consumer: the only writer of byte_ready, just after each rising edge.
  initial begin
    byte_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (ready_mode)
        0: byte_ready = 1'b0;
        1: byte_ready = 1'b1;
        2: begin
          phase_cnt++;
          if (phase_cnt == 3) begin phase_cnt = 0; byte_ready = ~byte_ready; end
        end
        default: byte_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor: every valid cycle must show the expected head byte.
  always @(negedge clk) begin
    if (!rst) begin
      if (frame_overrun) ovr_seen++;
      if (frame_timeout) to_seen++;
      if (byte_valid) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_byte: got %0h expected none", byte_out);
        end else begin
          check("byte_out", {24'd0, byte_out}, {24'd0, exp_q[0]});
          if (byte_ready) void'(exp_q.pop_front());
        end
      end
    end
  end

  // One chain bit with random legal phase lengths; starts and ends with
  // the chain clock low, just after a rising clk edge.
  task automatic send_bit(input logic b);
    debug_rx_data = b;
    repeat ($urandom_range(2, 4)) @(posedge clk);
    #1 debug_rx_clk = 1'b1;
    repeat ($urandom_range(2, 4)) @(posedge clk);
    #1 debug_rx_clk = 1'b0;
  endtask

  task automatic send_frame(input logic [143:0] f, input int nbits);
    for (int i = 0; i < nbits; i++) send_bit(f[143 - i]);
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 3000) begin @(posedge clk); n++; end
    if (exp_q.size() != 0) begin
      checks++; errors++;
      $display("FAIL %s_drain_timeout: got %0d bytes left expected 0", name, exp_q.size());
      exp_q.delete();
    end
    repeat (4) @(posedge clk);
    #1 check({name, "_valid_low"}, {31'd0, byte_valid}, 32'd0);
  endtask

  task automatic check_pulses(input string name);
    check({name, "_overruns"}, ovr_seen, exp_ovr);
    check({name, "_timeouts"}, to_seen, exp_to);
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_byte_out"}, {24'd0, byte_out}, 32'd0);
    check({name, "_byte_valid"}, {31'd0, byte_valid}, 32'd0);
    check({name, "_overrun"}, {31'd0, frame_overrun}, 32'd0);
    check({name, "_timeout"}, {31'd0, frame_timeout}, 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 check_reset_outputs("reset");
    rst = 1'b0;
    ovr_seen = 0; to_seen = 0; exp_ovr = 0; exp_to = 0; exp_frames = 0;
    @(posedge clk); #1;
  endtask

  // Watchdog: a hung run stops with a failure line.
  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [143:0] fa, fb;
    fa = {16'h2468, 128'h12345678_11223344_55667788_99AABBCC};
    rst = 1'b1; prescaler = 8'd2; debug_rx_data = 1'b0; debug_rx_clk = 1'b0;
    #1 check_reset_outputs("async_reset");
    @(posedge clk); #1;
    do_reset();

    // Identity return with the consumer always ready.
    ready_mode = 1;
    push_frame(fa); send_frame(fa, 144);
    wait_drain("identity"); check_pulses("identity");

    // Backpressure: ready toggles every three cycles.
    ready_mode = 2;
    push_frame(fa); send_frame(fa, 144);
    wait_drain("backpressure"); check_pulses("backpressure");

    // Overrun: second frame arrives while the first is still held.
    ready_mode = 0;
    fb = {$urandom, $urandom, $urandom, $urandom, 16'($urandom)};
    push_frame(fa); send_frame(fa, 144); send_frame(fb, 144);
    exp_ovr++;
    repeat (10) @(posedge clk); #1;
    check_pulses("overrun");
    ready_mode = 1;
    wait_drain("overrun");

    // Timeout: partial frame, chain idle well past 16 ticks of 3 cycles.
    send_frame(fb, 40);
    repeat (80) @(posedge clk); #1;
    exp_to++;
    check_pulses("timeout_partial");
    fb = {16'hFFFE, $urandom, $urandom, $urandom, 24'($urandom), 8'h00};
    push_frame(fb); send_frame(fb, 144);
    wait_drain("timeout"); check_pulses("timeout");

    // Reset mid-frame: the partial frame must vanish entirely.
    send_frame(fa, 70);
    do_reset();
    fb = {$urandom, $urandom, $urandom, $urandom, 16'($urandom)};
    push_frame(fb); send_frame(fb, 144);
    wait_drain("reset_mid"); check_pulses("reset_mid");

    // Boundary: frame B completes exactly as A's last byte is accepted.
    ready_mode = 0;
    push_frame(fa); send_frame(fa, 144);
    fb = {$urandom, $urandom, $urandom, $urandom, 16'($urandom)};
    push_frame(fb); send_frame(fb, 143);
    debug_rx_data = fb[0];
    @(negedge clk); ready_mode = 1;
    @(posedge clk);
    repeat (14) @(posedge clk);
    #1 debug_rx_clk = 1'b1;
    repeat (2) @(posedge clk);
    #1 debug_rx_clk = 1'b0;
    wait_drain("boundary"); check_pulses("boundary");

    // Random frames, random consumer, random prescaler.
    ready_mode = 3;
    prescaler = 8'($urandom_range(3, 40));
    for (int k = 0; k < 4; k++) begin
      fb = {$urandom, $urandom, $urandom, $urandom, 16'($urandom)};
      push_frame(fb); send_frame(fb, 144);
    end
    wait_drain("random"); check_pulses("random");

`ifdef SERIAL_DEBUG_FRAME_RX_STATS_EN
    check("stat_frames", {16'd0, stat_frames}, exp_frames);
    check("stat_overruns", {16'd0, stat_overruns}, exp_ovr);
    check("stat_timeouts", {16'd0, stat_timeouts}, exp_to);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
